// File: rtl/nios_mem_arb_pkg.sv
// Shared constants and types for the two-master on-chip RAM arbiter.
// NIOS_MEM_ARB_STATS_EN adds the statistics counter width.
package nios_mem_arb_pkg;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned DEPTH  = 10024;

  localparam logic [DATA_W-1:0] OOR_RDATA = 32'hDEAD_BEEF;

`ifdef NIOS_MEM_ARB_STATS_EN
  localparam int unsigned STAT_W = 16;
`endif

  typedef logic master_id_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic              wr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // Word addresses at or beyond the implemented depth are rejected
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return 32'(addr) < DEPTH;
  endfunction

endpackage

// File: rtl/nios_mem_arb_rr2.sv
// Two-way round-robin grant with last-granted register (m0 wins the first conflict).
module nios_mem_arb_rr2
  import nios_mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0,
  input  logic       req1,
  output logic       gnt0_c,
  output logic       gnt1_c,
  output master_id_t gnt_id_c,
  output logic       accept_c
);

  master_id_t last_gnt_q;
  master_id_t last_gnt_d;

  // The granted requester is always accepted, so any request means a transfer
  always_comb begin
    gnt_id_c   = 1'b0;
    last_gnt_d = last_gnt_q;
    if (req0 && req1) begin
      gnt_id_c = ~last_gnt_q;
    end else if (req1) begin
      gnt_id_c = 1'b1;
    end
    gnt0_c   = req0 & ~gnt_id_c;
    gnt1_c   = req1 & gnt_id_c;
    accept_c = req0 | req1;
    if (accept_c) begin
      last_gnt_d = gnt_id_c;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_gnt_q <= 1'b1;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

// File: rtl/nios_onchip_mem_arbiter.sv
// Shares a single-port on-chip RAM between two Avalon-MM masters with a 1-cycle read pipe.
// Optional per-master statistics counters under NIOS_MEM_ARB_STATS_EN.
module nios_onchip_mem_arbiter
  import nios_mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  output logic              m0_oor_err,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic              m1_oor_err,
`ifdef NIOS_MEM_ARB_STATS_EN
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_gnt0,
  output logic [STAT_W-1:0] stat_gnt1,
  output logic [STAT_W-1:0] stat_conflict,
`endif
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic       req0;
  logic       req1;
  logic       gnt0;
  logic       gnt1;
  logic       accept;
  master_id_t gnt_id;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  nios_mem_arb_rr2 u_rr2 (
    .clk      (clk),
    .reset_n  (reset_n),
    .req0     (req0),
    .req1     (req1),
    .gnt0_c   (gnt0),
    .gnt1_c   (gnt1),
    .gnt_id_c (gnt_id),
    .accept_c (accept)
  );

  assign m0_waitrequest = req0 & ~gnt0;
  assign m1_waitrequest = req1 & ~gnt1;

  mem_req_t req_sel_c;
  logic     in_range_c;
  logic     rd_acc_c;

  // Request mux; a simultaneous write and read is treated as a write only
  always_comb begin
    req_sel_c = '0;
    if (gnt_id) begin
      req_sel_c.addr  = m1_address;
      req_sel_c.be    = m1_byteenable;
      req_sel_c.wr    = m1_write;
      req_sel_c.wdata = m1_writedata;
    end else begin
      req_sel_c.addr  = m0_address;
      req_sel_c.be    = m0_byteenable;
      req_sel_c.wr    = m0_write;
      req_sel_c.wdata = m0_writedata;
    end
    in_range_c = addr_in_range(req_sel_c.addr);
    rd_acc_c   = accept & ~req_sel_c.wr;
  end

  assign mem_address    = req_sel_c.addr;
  assign mem_byteenable = req_sel_c.be;
  assign mem_writedata  = req_sel_c.wdata;
  assign mem_chipselect = accept & in_range_c;
  assign mem_write      = accept & in_range_c & req_sel_c.wr;

  logic       rd_vld_q, rd_vld_d;
  master_id_t rd_owner_q, rd_owner_d;
  logic       rd_oor_q, rd_oor_d;
  logic       oor0_q, oor0_d;
  logic       oor1_q, oor1_d;

  always_comb begin
    rd_vld_d   = rd_acc_c;
    rd_owner_d = gnt_id;
    rd_oor_d   = ~in_range_c;
    oor0_d     = accept & ~in_range_c & ~gnt_id;
    oor1_d     = accept & ~in_range_c & gnt_id;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld_q   <= 1'b0;
      rd_owner_q <= 1'b0;
      rd_oor_q   <= 1'b0;
      oor0_q     <= 1'b0;
      oor1_q     <= 1'b0;
    end else begin
      rd_vld_q   <= rd_vld_d;
      rd_owner_q <= rd_owner_d;
      rd_oor_q   <= rd_oor_d;
      oor0_q     <= oor0_d;
      oor1_q     <= oor1_d;
    end
  end

  assign m0_oor_err = oor0_q;
  assign m1_oor_err = oor1_q;

  // RAM q is only valid the cycle after the address, so read data is steered, not registered
  logic [DATA_W-1:0] rdata_c;
  always_comb begin
    rdata_c          = rd_oor_q ? OOR_RDATA : mem_readdata;
    m0_readdatavalid = rd_vld_q & ~rd_owner_q;
    m1_readdatavalid = rd_vld_q & rd_owner_q;
    m0_readdata      = m0_readdatavalid ? rdata_c : '0;
    m1_readdata      = m1_readdatavalid ? rdata_c : '0;
  end

`ifdef NIOS_MEM_ARB_STATS_EN
  logic [STAT_W-1:0] stat_gnt0_q, stat_gnt0_d;
  logic [STAT_W-1:0] stat_gnt1_q, stat_gnt1_d;
  logic [STAT_W-1:0] stat_conf_q, stat_conf_d;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
    return (en && (v != {STAT_W{1'b1}})) ? v + STAT_W'(1) : v;
  endfunction

  always_comb begin
    stat_gnt0_d = sat_inc(stat_gnt0_q, accept & ~gnt_id);
    stat_gnt1_d = sat_inc(stat_gnt1_q, accept & gnt_id);
    stat_conf_d = sat_inc(stat_conf_q, req0 & req1);
    if (stat_clr) begin
      stat_gnt0_d = '0;
      stat_gnt1_d = '0;
      stat_conf_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_gnt0_q <= '0;
      stat_gnt1_q <= '0;
      stat_conf_q <= '0;
    end else begin
      stat_gnt0_q <= stat_gnt0_d;
      stat_gnt1_q <= stat_gnt1_d;
      stat_conf_q <= stat_conf_d;
    end
  end

  assign stat_gnt0     = stat_gnt0_q;
  assign stat_gnt1     = stat_gnt1_q;
  assign stat_conflict = stat_conf_q;
`endif

endmodule

// File: tb/tb_nios_onchip_mem_arbiter.sv
// Bench for nios_onchip_mem_arbiter: vector table plus a read-data scoreboard.
// Exercises the statistics counters when NIOS_MEM_ARB_STATS_EN is defined.
module tb_nios_onchip_mem_arbiter;

  localparam int unsigned DEPTH_TB = 10024;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [13:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic        m0_oor_err, m1_oor_err;
  logic [13:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = 32'h0;
`ifdef NIOS_MEM_ARB_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif

  always #5 clk = ~clk;

  nios_onchip_mem_arbiter dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m0_oor_err       (m0_oor_err),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .m1_oor_err       (m1_oor_err),
`ifdef NIOS_MEM_ARB_STATS_EN
    .stat_clr         (stat_clr),
    .stat_gnt0        (stat_gnt0),
    .stat_gnt1        (stat_gnt1),
    .stat_conflict    (stat_conflict),
`endif
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_readdata     (mem_readdata)
  );

  // Single-port RAM slave, registered read port
  logic [31:0] ram [0:16383];
  logic [31:0] ram_merged;
  always_comb begin
    ram_merged = ram[mem_address];
    for (int b = 0; b < 4; b++)
      if (mem_byteenable[b]) ram_merged[8*b +: 8] = mem_writedata[8*b +: 8];
  end
  always @(posedge clk) begin
    if (mem_chipselect && mem_write) ram[mem_address] <= ram_merged;
    if (mem_chipselect && !mem_write) mem_readdata <= ram[mem_address];
  end

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [13:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mreq_t;

  typedef struct packed {
    mreq_t q0;
    mreq_t q1;
    logic  ew0;
    logic  ew1;
    logic  ecs;
    logic  emw;
  } vec_t;

  typedef struct {
    int          due;
    bit          owner;
    logic [31:0] data;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] mdl [int];
  logic [1:0]  exp_oor;
  int          cyc;
  int          total;
  int          bad;
  vec_t        vt[23];

  function automatic mreq_t idl();
    return '0;
  endfunction
  function automatic mreq_t rdq(input logic [13:0] a);
    mreq_t q = '0;
    q.rd = 1'b1; q.addr = a;
    return q;
  endfunction
  function automatic mreq_t wrq(input logic [13:0] a, input logic [3:0] be, input logic [31:0] d);
    mreq_t q = '0;
    q.wr = 1'b1; q.addr = a; q.be = be; q.wdata = d;
    return q;
  endfunction
  function automatic vec_t mk(input mreq_t q0, input mreq_t q1, input logic [3:0] e);
    vec_t v;
    v.q0 = q0; v.q1 = q1;
    {v.ew0, v.ew1, v.ecs, v.emw} = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input mreq_t q0, input mreq_t q1);
    m0_read = q0.rd; m0_write = q0.wr; m0_address = q0.addr;
    m0_byteenable = q0.be; m0_writedata = q0.wdata;
    m1_read = q1.rd; m1_write = q1.wr; m1_address = q1.addr;
    m1_byteenable = q1.be; m1_writedata = q1.wdata;
  endtask

  function automatic logic [31:0] mdl_rd(input logic [13:0] a);
    if (32'(a) >= DEPTH_TB) return 32'hDEAD_BEEF;
    return mdl.exists(int'(a)) ? mdl[int'(a)] : 32'h0;
  endfunction

  // Called just after a rising edge; returns just after the next one
  task automatic drive_cycle(input string tag, input vec_t v);
    mreq_t       g;
    bit          gid;
    bit          due_now;
    logic [31:0] w;
    apply(v.q0, v.q1);
    @(negedge clk);
    chk({tag, " wait0"}, 32'(m0_waitrequest), 32'(v.ew0));
    chk({tag, " wait1"}, 32'(m1_waitrequest), 32'(v.ew1));
    chk({tag, " cs"}, 32'(mem_chipselect), 32'(v.ecs));
    chk({tag, " mwr"}, 32'(mem_write), 32'(v.emw));
    gid = !((v.q0.rd || v.q0.wr) && !v.ew0);
    g   = gid ? v.q1 : v.q0;
    if (v.ecs) chk({tag, " maddr"}, 32'(mem_address), 32'(g.addr));
    if (v.emw) chk({tag, " mwdata"}, mem_writedata, g.wdata);
    due_now = (sb.size() > 0) && (sb[0].due == cyc);
    chk({tag, " rdv0"}, 32'(m0_readdatavalid), 32'(due_now && !sb[0].owner));
    chk({tag, " rdv1"}, 32'(m1_readdatavalid), 32'(due_now && sb[0].owner));
    if (due_now) begin
      chk({tag, " rdata"}, sb[0].owner ? m1_readdata : m0_readdata, sb[0].data);
      void'(sb.pop_front());
    end
    chk({tag, " oor0"}, 32'(m0_oor_err), 32'(exp_oor[0]));
    chk({tag, " oor1"}, 32'(m1_oor_err), 32'(exp_oor[1]));
    exp_oor = '0;
    if ((g.rd || g.wr) && !(gid ? v.ew1 : v.ew0)) begin
      if (32'(g.addr) >= DEPTH_TB) exp_oor[gid] = 1'b1;
      if (!g.wr) begin
        sb.push_back('{due: cyc + 1, owner: gid, data: mdl_rd(g.addr)});
      end else if (32'(g.addr) < DEPTH_TB) begin
        w = mdl_rd(g.addr);
        for (int b = 0; b < 4; b++)
          if (g.be[b]) w[8*b +: 8] = g.wdata[8*b +: 8];
        mdl[int'(g.addr)] = w;
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; exp_oor = '0;
    for (int i = 0; i < 16384; i++) ram[i] = 32'h0;
    reset_n = 1'b0;
    apply(idl(), idl());

    // ew0 ew1 cs mwr
    vt[0]  = mk(wrq(14'd5, 4'hF, 32'h1234_5678), idl(), 4'b0011);
    vt[1]  = mk(rdq(14'd5), idl(), 4'b0010);
    vt[2]  = mk(idl(), idl(), 4'b0000);
    vt[3]  = mk(idl(), wrq(14'd100, 4'b0010, 32'hAABB_CCDD), 4'b0011);
    vt[4]  = mk(idl(), rdq(14'd100), 4'b0010);
    vt[5]  = mk(wrq(14'd10024, 4'hF, 32'h1111_1111), idl(), 4'b0000);
    vt[6]  = mk(rdq(14'd10030), idl(), 4'b0000);
    vt[7]  = mk(wrq(14'd10023, 4'hF, 32'hCAFE_F00D), idl(), 4'b0011);
    vt[8]  = mk(rdq(14'd10023), idl(), 4'b0010);
    vt[9]  = mk(idl(), wrq(14'd7, 4'hF, 32'h7777_7777), 4'b0011);
    vt[9].q1.rd = 1'b1;
    vt[10] = mk(idl(), rdq(14'd7), 4'b0010);
    for (int i = 0; i < 8; i++)
      vt[11+i] = mk(rdq(14'd5), rdq(14'd100), (i % 2 == 0) ? 4'b0110 : 4'b1010);
    vt[19] = mk(wrq(14'd200, 4'b1100, 32'hA5A5_5A5A), rdq(14'd5), 4'b0111);
    vt[20] = mk(idl(), rdq(14'd5), 4'b0010);
    vt[21] = mk(rdq(14'd200), idl(), 4'b0010);
    vt[22] = mk(idl(), idl(), 4'b0000);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst rdv0", 32'(m0_readdatavalid), 32'h0);
    chk("rst rdv1", 32'(m1_readdatavalid), 32'h0);
    chk("rst rdata0", m0_readdata, 32'h0);
    chk("rst rdata1", m1_readdata, 32'h0);
    chk("rst oor", 32'({m1_oor_err, m0_oor_err}), 32'h0);
`ifdef NIOS_MEM_ARB_STATS_EN
    chk("rst stat", 32'(stat_gnt0 | stat_gnt1 | stat_conflict), 32'h0);
`endif
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 23; i++) drive_cycle($sformatf("v%0d", i), vt[i]);
    chk("sb drained", 32'(sb.size()), 32'h0);

    // Read in flight when reset hits must never be delivered
    drive_cycle("rst_rd", mk(rdq(14'd5), idl(), 4'b0010));
    reset_n = 1'b0;
    apply(idl(), idl());
    @(negedge clk);
    chk("midrst rdv0", 32'(m0_readdatavalid), 32'h0);
    chk("midrst rdata0", m0_readdata, 32'h0);
    sb.delete();
    exp_oor = '0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    drive_cycle("post0", mk(rdq(14'd5), rdq(14'd100), 4'b0110));
    drive_cycle("post1", mk(rdq(14'd5), rdq(14'd100), 4'b1010));
    drive_cycle("post2", mk(idl(), idl(), 4'b0000));
    drive_cycle("post3", mk(idl(), idl(), 4'b0000));

`ifdef NIOS_MEM_ARB_STATS_EN
    apply(idl(), rdq(14'd5));
    repeat (70000) @(posedge clk);
    #1 apply(idl(), idl());
    @(negedge clk);
    chk("stat_gnt1 sat", 32'(stat_gnt1), 32'h0000_FFFF);
    @(posedge clk); #1 stat_clr = 1'b1;
    @(posedge clk); #1 stat_clr = 1'b0;
    @(negedge clk);
    chk("stat_clr", 32'(stat_gnt0 | stat_gnt1 | stat_conflict), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
